lbuf_gen: RTL and testbench

LBUF_GEN -- requirements
Module: lbuf_gen

---
 rtl/lbuf_gen_pkg.sv | 18 +
 rtl/lbuf_gen_ram.sv | 27 ++
 rtl/lbuf_gen.sv | 194 +++++++++++++++++++
 tb/tb_lbuf_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbuf_gen_pkg.sv
// Shared types and sizing helpers for the line-buffer generator.
package lbuf_gen_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 9;
  localparam int NBUF_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Buffer-index width: one bit minimum even when only two buffers exist.
  function automatic int bw_of(input int nbuf);
    return (nbuf > 2) ? $clog2(nbuf) : 1;
  endfunction

endpackage

// File: rtl/lbuf_gen_ram.sv
// Single line buffer: one byte-enabled write port, one registered read port.
module lbuf_gen_ram #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lbuf_gen.sv
// Rotating set of line buffers with swap handshake, background clear engine
// and a lowest-priority CPU access port.
module lbuf_gen
  import lbuf_gen_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NBUF = NBUF_DEF,
  localparam int BW  = bw_of(NBUF)
) (
  input  logic            sys_clk,
  input  logic            resetl,
  input  logic            wr_req,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  output logic            wr_rdy,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_vld,
  input  logic            swap_req,
  output logic            swap_ack,
  input  logic            clr_en,
  input  logic [DW-1:0]   bg_data,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [BW-1:0]   cpu_buf,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_ack,
  output logic [BW-1:0]   wbuf,
  output logic [BW-1:0]   rbuf,
  output logic            busy
);

  localparam int NSLOT = 2**BW;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  clr_state_t    state, state_nx;
  logic [AW-1:0] clr_addr;
  logic [BW-1:0] clr_buf;
  logic          swap_pend;
  logic          swap_go;
  logic          wr_go;
  logic          cpu_valid;
  logic          cpu_wr_blk;
  logic          cpu_rd_blk;
  logic          cpu_grant;

  logic            ram_we [NBUF];
  logic [DW/8-1:0] ram_be [NBUF];
  logic [AW-1:0]   ram_wa [NBUF];
  logic [DW-1:0]   ram_wd [NBUF];
  logic            ram_re [NBUF];
  logic [AW-1:0]   ram_ra [NBUF];
  logic [DW-1:0]   ram_q  [NSLOT];

  logic [BW-1:0] rd_sel_p1;
  logic [BW-1:0] cpu_sel_p1;
  logic          cpu_rd_p1;
  logic [DW-1:0] rd_hold;
  logic [DW-1:0] cpu_hold;

  assign busy      = (state == ST_CLEAR);
  assign wr_rdy    = !(busy && (clr_buf == wbuf)) && !swap_pend;
  assign wr_go     = wr_req && wr_rdy;
  assign swap_go   = (swap_req || swap_pend) && !busy;

  // Out-of-range CPU buffers are granted immediately and touch no memory.
  assign cpu_valid  = (int'(cpu_buf) < NBUF);
  assign cpu_wr_blk = (busy && (clr_buf == cpu_buf)) || (wr_go && (wbuf == cpu_buf));
  assign cpu_rd_blk = rd_en && (rbuf == cpu_buf);
  assign cpu_grant  = cpu_req && !cpu_ack &&
                      (!cpu_valid || (cpu_we ? !cpu_wr_blk : !cpu_rd_blk));

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (swap_go && clr_en) state_nx = ST_CLEAR;
      ST_CLEAR: if (clr_addr == LAST_ADDR) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      wbuf      <= '0;
      rbuf      <= BW'(NBUF-1);
      swap_pend <= 1'b0;
      swap_ack  <= 1'b0;
      clr_buf   <= '0;
      clr_addr  <= '0;
    end else begin
      swap_ack <= swap_go;
      if (swap_go) begin
        wbuf      <= (wbuf == BW'(NBUF-1)) ? '0 : wbuf + BW'(1);
        rbuf      <= wbuf;
        swap_pend <= 1'b0;
        if (clr_en) begin
          clr_buf  <= rbuf;
          clr_addr <= '0;
        end
      end else if (swap_req && busy) begin
        swap_pend <= 1'b1;
      end
      // Counter wraps to zero on the last word, which is also the FSM exit.
      if (busy) clr_addr <= clr_addr + AW'(1);
    end
  end

  // Per-buffer port steering: clear > object write > CPU; video read > CPU.
  always_comb begin
    for (int i = 0; i < NBUF; i++) begin
      ram_we[i] = 1'b0;
      ram_be[i] = '0;
      ram_wa[i] = '0;
      ram_wd[i] = '0;
      ram_re[i] = 1'b0;
      ram_ra[i] = '0;
      if (busy && (clr_buf == BW'(i))) begin
        ram_we[i] = 1'b1;
        ram_be[i] = '1;
        ram_wa[i] = clr_addr;
        ram_wd[i] = bg_data;
      end else if (wr_go && (wbuf == BW'(i))) begin
        ram_we[i] = 1'b1;
        ram_be[i] = wr_be;
        ram_wa[i] = wr_addr;
        ram_wd[i] = wr_data;
      end else if (cpu_grant && cpu_we && (cpu_buf == BW'(i))) begin
        ram_we[i] = 1'b1;
        ram_be[i] = '1;
        ram_wa[i] = cpu_addr;
        ram_wd[i] = cpu_wdata;
      end
      if (rd_en && (rbuf == BW'(i))) begin
        ram_re[i] = 1'b1;
        ram_ra[i] = rd_addr;
      end else if (cpu_grant && !cpu_we && (cpu_buf == BW'(i))) begin
        ram_re[i] = 1'b1;
        ram_ra[i] = cpu_addr;
      end
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_buf
    if (g < NBUF) begin : g_ram
      lbuf_gen_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (sys_clk),
        .we    (ram_we[g]),
        .waddr (ram_wa[g]),
        .wdata (ram_wd[g]),
        .be    (ram_be[g]),
        .re    (ram_re[g]),
        .raddr (ram_ra[g]),
        .rdata (ram_q[g])
      );
    end else begin : g_pad
      assign ram_q[g] = '0;
    end
  end

  // p1: RAM output valid; steer to the requesting port, otherwise hold.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      rd_vld     <= 1'b0;
      rd_sel_p1  <= '0;
      cpu_ack    <= 1'b0;
      cpu_rd_p1  <= 1'b0;
      cpu_sel_p1 <= '0;
      rd_hold    <= '0;
      cpu_hold   <= '0;
    end else begin
      rd_vld     <= rd_en;
      rd_sel_p1  <= rbuf;
      cpu_ack    <= cpu_grant;
      cpu_rd_p1  <= cpu_grant && !cpu_we && cpu_valid;
      cpu_sel_p1 <= cpu_buf;
      if (rd_vld)  rd_hold  <= rd_data;
      if (cpu_ack) cpu_hold <= cpu_rdata;
    end
  end

  assign rd_data   = rd_vld ? ram_q[rd_sel_p1] : rd_hold;
  assign cpu_rdata = cpu_ack ? (cpu_rd_p1 ? ram_q[cpu_sel_p1] : '0) : cpu_hold;

endmodule

// File: tb/tb_lbuf_gen.sv
// Directed bench for lbuf_gen: a two-buffer instance for data/clear/CPU paths
// and a small three-buffer instance for rotation order and invalid CPU buffers.
module tb_lbuf_gen;

  logic sys_clk = 1'b0;
  logic resetl  = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        wr_req, wr_rdy, rd_en, rd_vld, swap_req, swap_ack, clr_en;
  logic [8:0]  wr_addr, rd_addr, cpu_addr;
  logic [31:0] wr_data, rd_data, bg_data, cpu_wdata, cpu_rdata;
  logic [3:0]  wr_be;
  logic        cpu_req, cpu_we, cpu_ack, busy;
  logic        cpu_buf, wbuf, rbuf;

  logic        b_wr_req, b_wr_rdy, b_rd_en, b_rd_vld, b_swap_req, b_swap_ack, b_clr_en;
  logic [3:0]  b_wr_addr, b_rd_addr, b_cpu_addr;
  logic [31:0] b_wr_data, b_rd_data, b_bg_data, b_cpu_wdata, b_cpu_rdata;
  logic [3:0]  b_wr_be;
  logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_busy;
  logic [1:0]  b_cpu_buf, b_wbuf, b_rbuf;

  lbuf_gen u_dut (
    .sys_clk(sys_clk), .resetl(resetl),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_rdy(wr_rdy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld),
    .swap_req(swap_req), .swap_ack(swap_ack), .clr_en(clr_en), .bg_data(bg_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_buf(cpu_buf), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .wbuf(wbuf), .rbuf(rbuf), .busy(busy)
  );

  lbuf_gen #(.DW(32), .AW(4), .NBUF(3)) u_dut3 (
    .sys_clk(sys_clk), .resetl(resetl),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be), .wr_rdy(b_wr_rdy),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_vld(b_rd_vld),
    .swap_req(b_swap_req), .swap_ack(b_swap_ack), .clr_en(b_clr_en), .bg_data(b_bg_data),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_buf(b_cpu_buf), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .wbuf(b_wbuf), .rbuf(b_rbuf), .busy(b_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum int { OP_WR, OP_WRSWAP, OP_RD } op_t;
  typedef struct {
    op_t         op;
    logic [8:0]  addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  be;
  } vec_t;

  vec_t vt [0:13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic wr_word(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic vid_read(input logic [8:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk($sformatf("rd_vld@%0d", a), rd_vld, 1);
    chk($sformatf("rd_data@%0d", a), rd_data, exp);
  endtask

  task automatic do_swap(input logic ce);
    swap_req = 1'b1; clr_en = ce;
    tick();
    swap_req = 1'b0; clr_en = 1'b0;
    chk("swap_ack", swap_ack, 1);
  endtask

  task automatic cpu_acc(input logic we, input logic bsel, input logic [8:0] a,
                         input logic [31:0] d, output logic [31:0] rdat);
    bit acked = 0;
    rdat = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_buf = bsel; cpu_addr = a; cpu_wdata = d;
    for (int k = 0; k < 6 && !acked; k++) begin
      tick();
      if (cpu_ack) begin acked = 1; rdat = cpu_rdata; end
    end
    cpu_req = 1'b0;
    if (!acked) chk("cpu_ack_timeout", 0, 1);
  endtask

  task automatic b_cpu_acc(input logic we, input logic [1:0] bsel, input logic [3:0] a,
                           input logic [31:0] d, output logic [31:0] rdat);
    bit acked = 0;
    rdat = '0;
    b_cpu_req = 1'b1; b_cpu_we = we; b_cpu_buf = bsel; b_cpu_addr = a; b_cpu_wdata = d;
    for (int k = 0; k < 6 && !acked; k++) begin
      tick();
      if (b_cpu_ack) begin acked = 1; rdat = b_cpu_rdata; end
    end
    b_cpu_req = 1'b0;
    chk("b_cpu_acked", 32'(acked), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          cnt_busy, cnt_rdy, errs, acks;
    logic [1:0]  exp_w [3];
    logic [1:0]  exp_r [3];

    wr_req = 0; wr_addr = 0; wr_data = 0; wr_be = 0; rd_en = 0; rd_addr = 0;
    swap_req = 0; clr_en = 0; bg_data = 0;
    cpu_req = 0; cpu_we = 0; cpu_buf = 0; cpu_addr = 0; cpu_wdata = 0;
    b_wr_req = 0; b_wr_addr = 0; b_wr_data = 0; b_wr_be = 0; b_rd_en = 0; b_rd_addr = 0;
    b_swap_req = 0; b_clr_en = 0; b_bg_data = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_buf = 0; b_cpu_addr = 0; b_cpu_wdata = 0;

    vt[0]  = '{OP_WR,     9'd5,   32'h11111111, 4'hF};
    vt[1]  = '{OP_WR,     9'd5,   32'hDEADBEEF, 4'h3};
    vt[2]  = '{OP_WR,     9'd0,   32'hA5A5A5A5, 4'hF};
    vt[3]  = '{OP_WR,     9'd0,   32'h00000000, 4'h8};
    vt[4]  = '{OP_WR,     9'd511, 32'hCAFEF00D, 4'hF};
    vt[5]  = '{OP_WR,     9'd511, 32'h12345678, 4'h4};
    vt[6]  = '{OP_WR,     9'd9,   32'h87654321, 4'hF};
    vt[7]  = '{OP_WR,     9'd9,   32'hFFFFFFFF, 4'hA};
    vt[8]  = '{OP_WRSWAP, 9'd12,  32'h0BADCAFE, 4'hF};
    vt[9]  = '{OP_RD,     9'd5,   32'h1111BEEF, 4'h0};
    vt[10] = '{OP_RD,     9'd0,   32'h00A5A5A5, 4'h0};
    vt[11] = '{OP_RD,     9'd511, 32'hCA34F00D, 4'h0};
    vt[12] = '{OP_RD,     9'd9,   32'hFF65FF21, 4'h0};
    vt[13] = '{OP_RD,     9'd12,  32'h0BADCAFE, 4'h0};

    // Reset state
    tick(); tick();
    chk("rst_wbuf", wbuf, 0);
    chk("rst_rbuf", rbuf, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_b_wbuf", b_wbuf, 0);
    chk("rst_b_rbuf", b_rbuf, 2);
    resetl = 1'b1;
    tick();

    // Three-buffer rotation
    exp_w = '{2'd1, 2'd2, 2'd0};
    exp_r = '{2'd0, 2'd1, 2'd2};
    for (int k = 0; k < 3; k++) begin
      b_swap_req = 1'b1;
      tick();
      b_swap_req = 1'b0;
      chk($sformatf("b_swap_ack%0d", k), b_swap_ack, 1);
      chk($sformatf("b_wbuf%0d", k), b_wbuf, exp_w[k]);
      chk($sformatf("b_rbuf%0d", k), b_rbuf, exp_r[k]);
      tick();
    end
    b_cpu_acc(1'b1, 2'd0, 4'd3, 32'hABCD1234, r);
    b_cpu_acc(1'b0, 2'd0, 4'd3, 32'h0, r);
    chk("b_cpu_rd_buf0", r, 32'hABCD1234);
    b_cpu_acc(1'b1, 2'd3, 4'd3, 32'h55555555, r);
    b_cpu_acc(1'b0, 2'd3, 4'd3, 32'h0, r);
    chk("b_cpu_rd_invalid", r, 32'h0);

    // Byte-enabled writes, write coinciding with swap, video reads
    for (int i = 0; i < 14; i++) begin
      case (vt[i].op)
        OP_WR: wr_word(vt[i].addr, vt[i].data, vt[i].be);
        OP_WRSWAP: begin
          wr_req = 1'b1; wr_addr = vt[i].addr; wr_data = vt[i].data; wr_be = vt[i].be;
          swap_req = 1'b1; clr_en = 1'b0;
          tick();
          wr_req = 1'b0; swap_req = 1'b0;
          chk("swap_ack_wr", swap_ack, 1);
          chk("swap_wbuf", wbuf, 1);
          chk("swap_rbuf", rbuf, 0);
        end
        default: vid_read(vt[i].addr, vt[i].data);
      endcase
    end
    tick();
    chk("rd_vld_idle", rd_vld, 0);
    chk("rd_data_hold", rd_data, 32'h0BADCAFE);

    // CPU write/read of the write buffer
    cpu_acc(1'b1, 1'b1, 9'd20, 32'h13572468, r);
    cpu_acc(1'b0, 1'b1, 9'd20, 32'h0, r);
    chk("cpu_rd_wbuf", r, 32'h13572468);

    // CPU read of rbuf is starved while the video port keeps reading it
    rd_en = 1'b1; rd_addr = 9'd5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_buf = 1'b0; cpu_addr = 9'd9;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (cpu_ack) acks++;
    end
    chk("cpu_starved_acks", acks, 0);
    rd_en = 1'b0;
    acks = 0;
    for (int k = 0; k < 5 && acks == 0; k++) begin
      tick();
      if (cpu_ack) begin acks = 1; r = cpu_rdata; end
    end
    cpu_req = 1'b0;
    chk("cpu_ack_after_rd", acks, 1);
    chk("cpu_rdata_after_rd", r, 32'hFF65FF21);
    tick();

    // Clear of the retired buffer (buffer 0), which becomes the write buffer
    bg_data = 32'h0;
    do_swap(1'b1);
    chk("clr_wbuf", wbuf, 0);
    chk("clr_rbuf", rbuf, 1);
    cnt_busy = 0; cnt_rdy = 0;
    for (int k = 0; k < 2000 && busy; k++) begin
      cnt_busy++;
      if (!wr_rdy) cnt_rdy++;
      tick();
    end
    chk("clr_busy_cycles", cnt_busy, 512);
    chk("clr_rdy_low_cycles", cnt_rdy, 512);
    chk("clr_wr_rdy_after", wr_rdy, 1);
    errs = 0;
    for (int a = 0; a < 512; a++) begin
      cpu_acc(1'b0, 1'b0, 9'(a), 32'h0, r);
      if (r !== 32'h0) errs++;
    end
    chk("clr_all_zero_errs", errs, 0);

    // Swap requested during a clear is held, then executes once
    do_swap(1'b1);
    repeat (10) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("pend_no_ack", swap_ack, 0);
    chk("pend_wr_rdy", wr_rdy, 0);
    repeat (5) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int k = 0; k < 1000 && busy; k++) tick();
    chk("pend_busy_fell", busy, 0);
    chk("pend_ack_not_yet", swap_ack, 0);
    tick();
    chk("pend_ack", swap_ack, 1);
    chk("pend_wbuf", wbuf, 0);
    chk("pend_rbuf", rbuf, 1);
    tick();
    chk("pend_ack_single", swap_ack, 0);
    chk("pend_wbuf_once", wbuf, 0);
    chk("pend_no_clear", busy, 0);

    // Reset in the middle of a clear
    cpu_acc(1'b1, 1'b1, 9'd100, 32'h600DF00D, r);
    do_swap(1'b1);
    repeat (20) tick();
    chk("mid_clr_busy", busy, 1);
    #2 resetl = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wbuf", wbuf, 0);
    chk("rst_mid_rbuf", rbuf, 1);
    chk("rst_mid_wr_rdy", wr_rdy, 1);
    tick();
    resetl = 1'b1;
    tick();
    cpu_acc(1'b0, 1'b1, 9'd100, 32'h0, r);
    chk("rst_mid_no_more_clear", r, 32'h600DF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
